// File: rtl/jtag_user_bridge_if.sv
// Signal bundle between the BSCANE2-facing TAP decode and the user bridge.
// The master side is the TAP/solver environment; the slave side is the bridge.
interface jtag_user_bridge_if #(
    parameter int RESULT_WIDTH = 32,
    parameter int BYTE_WIDTH   = 8
);
    logic                    tdi;
    logic                    tdo;
    logic                    run_test_idle;
    logic                    ir_is_user;
    logic                    capture_dr;
    logic                    shift_dr;
    logic                    update_dr;
    logic [RESULT_WIDTH-1:0] result;
    logic                    result_valid;
    logic                    byte_valid;
    logic [BYTE_WIDTH-1:0]   byte_data;
    logic                    frame_error;

    modport master (
        output tdi, run_test_idle, ir_is_user, capture_dr, shift_dr, update_dr,
        output result, result_valid,
        input  tdo, byte_valid, byte_data, frame_error
    );

    modport slave (
        input  tdi, run_test_idle, ir_is_user, capture_dr, shift_dr, update_dr,
        input  result, result_valid,
        output tdo, byte_valid, byte_data, frame_error
    );
endinterface

// File: rtl/jtag_user_bridge.sv
// USER4 DR-scan bridge: 8-bit inbound scans become byte strobes, readback scans shift out the held result.
// Optional bad-length detection is enabled by defining JTAG_USER_BRIDGE_FRAME_CHECK_EN.
module jtag_user_bridge #(
    parameter int RESULT_WIDTH = 32,
    parameter int BYTE_WIDTH   = 8
) (
    input  logic              tck,
    input  logic              test_logic_reset,
    jtag_user_bridge_if.slave bus
);

    if (RESULT_WIDTH <= 8 || RESULT_WIDTH > 63) begin : g_bad_width
        $error("jtag_user_bridge: RESULT_WIDTH must be > 8 and <= 63");
    end

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_UPD
    } state_t;

    state_t                  state;
    logic [5:0]              count;
    logic [BYTE_WIDTH-1:0]   in_sr;
    logic [RESULT_WIDTH-1:0] out_sr;
    logic [RESULT_WIDTH-1:0] hold;
    logic                    byte_valid;
    logic [BYTE_WIDTH-1:0]   byte_data;

    logic dr_cap;
    logic dr_shift;
    logic dr_upd;
    logic count_is_byte;

    assign dr_cap        = bus.ir_is_user & bus.capture_dr;
    assign dr_shift      = bus.ir_is_user & bus.shift_dr;
    assign dr_upd        = bus.ir_is_user & bus.update_dr;
    assign count_is_byte = (count == 6'(BYTE_WIDTH));

    // Run-Test/Idle carries no meaning for this bridge.
    logic unused_inputs;
    assign unused_inputs = bus.run_test_idle;

    // NOTE: reset is sampled inside the clocked block (synchronous); all state
    // uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge tck) begin
        if (test_logic_reset) begin
            state      <= IDLE;
            count      <= '0;
            in_sr      <= '0;
            out_sr     <= '0;
            hold       <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
        end else begin
            byte_valid <= 1'b0;

            if (bus.result_valid) begin
                hold <= bus.result;
            end

            // Capture wins over shift; a result strobe coincident with capture is loaded directly.
            if (dr_cap) begin
                count  <= '0;
                in_sr  <= '0;
                out_sr <= bus.result_valid ? bus.result : hold;
            end else if (dr_shift) begin
                if (count != 6'd63) begin
                    count <= count + 6'd1;
                end
                in_sr  <= {bus.tdi, in_sr[BYTE_WIDTH-1:1]};
                out_sr <= {1'b0, out_sr[RESULT_WIDTH-1:1]};
            end

            if (dr_upd && count_is_byte) begin
                byte_data  <= in_sr;
                byte_valid <= 1'b1;
            end

            // With the user instruction deselected the FSM freezes in place.
            if (bus.ir_is_user) begin
                if (dr_upd) begin
                    state <= IDLE;
                end else begin
                    case (state)
                        IDLE:     if (dr_cap) state <= SHIFT;
                        SHIFT:    if (!dr_shift && !dr_cap) state <= WAIT_UPD;
                        WAIT_UPD: if (dr_shift || dr_cap) state <= SHIFT;
                        default:  state <= IDLE;
                    endcase
                end
            end
        end
    end

`ifdef JTAG_USER_BRIDGE_FRAME_CHECK_EN
    logic frame_error;

    // Sticky until reset: any update whose length is neither a byte nor a readback.
    always_ff @(posedge tck) begin
        if (test_logic_reset) begin
            frame_error <= 1'b0;
        end else if (dr_upd && !count_is_byte && (count != 6'(RESULT_WIDTH))) begin
            frame_error <= 1'b1;
        end
    end

    assign bus.frame_error = frame_error;
`else
    assign bus.frame_error = 1'b0;
`endif

    assign bus.tdo        = out_sr[0];
    assign bus.byte_valid = byte_valid;
    assign bus.byte_data  = byte_data;

endmodule

// File: tb/tb_jtag_user_bridge.sv
// Directed bench for jtag_user_bridge: scan-level host tasks, byte scoreboard, readback compares.
// Frame-error expectations follow JTAG_USER_BRIDGE_FRAME_CHECK_EN.
module tb_jtag_user_bridge;

    localparam int RW = 32;
    localparam int BW = 8;

    logic tck = 1'b0;
    logic rst = 1'b1;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    logic [BW-1:0] sb[$];

    jtag_user_bridge_if #(.RESULT_WIDTH(RW), .BYTE_WIDTH(BW)) bus ();

    jtag_user_bridge #(.RESULT_WIDTH(RW), .BYTE_WIDTH(BW)) dut (
        .tck              (tck),
        .test_logic_reset (rst),
        .bus              (bus)
    );

    always #5 tck = ~tck;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every byte strobe must match the oldest expected byte; extra strobes fail.
    always @(negedge tck) begin
        if (bus.byte_valid) begin
            check("byte_strobe_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) check("byte_data", 64'(bus.byte_data), 64'(sb.pop_front()));
        end
    end

    // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
    task automatic cyc();
        @(posedge tck);
        @(negedge tck);
    endtask

    task automatic capture();
        bus.capture_dr = 1'b1;
        cyc();
        bus.capture_dr = 1'b0;
    endtask

    task automatic shift(input logic b, output logic o);
        o          = bus.tdo;
        bus.tdi    = b;
        bus.shift_dr = 1'b1;
        cyc();
        bus.shift_dr = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) cyc();
    endtask

    task automatic pulse_result(input logic [RW-1:0] v);
        bus.result       = v;
        bus.result_valid = 1'b1;
        cyc();
        bus.result_valid = 1'b0;
    endtask

    task automatic update(input string tag, input logic exp_bv);
        bus.update_dr = 1'b1;
        cyc();
        bus.update_dr = 1'b0;
        check({tag, "_strobe"}, 64'(bus.byte_valid), 64'(exp_bv));
        cyc();
        check({tag, "_strobe_end"}, 64'(bus.byte_valid), 64'd0);
    endtask

    task automatic scan(input logic [127:0] din, input int n, output logic [127:0] dout);
        logic o;
        dout = '0;
        capture();
        for (int i = 0; i < n; i++) begin
            shift(din[i], o);
            dout[i] = o;
        end
        gap(1);
    endtask

    initial begin
        logic [127:0] dout;
        logic o;

        bus.tdi           = 1'b0;
        bus.run_test_idle = 1'b0;
        bus.ir_is_user    = 1'b1;
        bus.capture_dr    = 1'b0;
        bus.shift_dr      = 1'b0;
        bus.update_dr     = 1'b0;
        bus.result        = '0;
        bus.result_valid  = 1'b0;

        @(negedge tck);
        gap(2);
        rst = 1'b0;
        check("reset_tdo", 64'(bus.tdo), 64'd0);
        check("reset_byte_valid", 64'(bus.byte_valid), 64'd0);
        check("reset_byte_data", 64'(bus.byte_data), 64'd0);
        check("reset_frame_error", 64'(bus.frame_error), 64'd0);

        // Inbound byte 0x41.
        sb.push_back(8'h41);
        scan(128'h41, 8, dout);
        update("byte_41", 1'b1);
        check("byte_data_hold", 64'(bus.byte_data), 64'h41);

        // Readback before any result is latched.
        scan('0, 32, dout);
        update("rb_empty", 1'b0);
        check("rb_empty_value", dout[63:0], 64'h0);

        // Result strobe mid-scan leaves the in-flight readback untouched.
        capture();
        for (int i = 0; i < 32; i++) begin
            if (i == 10) pulse_result(32'hDEAD_BEEF);
            shift(1'b0, o);
            dout[i] = o;
        end
        gap(1);
        update("rb_inflight", 1'b0);
        check("rb_inflight_value", 64'(dout[31:0]), 64'h0);
        scan('0, 32, dout);
        update("rb_deadbeef", 1'b0);
        check("rb_deadbeef_value", dout[63:0], 64'hDEAD_BEEF);

        pulse_result(32'h0000_1234);
        scan('0, 32, dout);
        update("rb_1234", 1'b0);
        check("rb_1234_value", dout[63:0], 64'h1234);

        // Result strobe coincident with capture is loaded by that capture.
        bus.result       = 32'h5555_AAAA;
        bus.result_valid = 1'b1;
        bus.capture_dr   = 1'b1;
        cyc();
        bus.result_valid = 1'b0;
        bus.capture_dr   = 1'b0;
        dout = '0;
        for (int i = 0; i < 32; i++) begin
            shift(1'b0, o);
            dout[i] = o;
        end
        gap(1);
        update("rb_cap_same", 1'b0);
        check("rb_cap_same_value", dout[63:0], 64'h5555_AAAA);

        // 72 shifts: zeros past the result, count saturates so no byte appears.
        scan('0, 72, dout);
        update("rb_long", 1'b0);
        check("rb_long_low", 64'(dout[31:0]), 64'h5555_AAAA);
        check("rb_long_tail", dout[95:32], 64'h0);

        // Split byte with a 3-cycle pause: 0x0A.
        sb.push_back(8'h0A);
        capture();
        for (int i = 0; i < 4; i++) shift(i[0], o);
        gap(3);
        for (int i = 0; i < 4; i++) shift(1'b0, o);
        gap(1);
        update("byte_0a", 1'b1);

        // Byte scan that also reads back 8 bits of 0x155, leaving tdo = 1.
        pulse_result(32'h0000_0155);
        sb.push_back(8'h3C);
        scan(128'h3C, 8, dout);
        update("byte_3c", 1'b1);
        check("byte_3c_readback", 64'(dout[7:0]), 64'h55);
        check("tdo_after_partial", 64'(bus.tdo), 64'd1);

        // USER4 deselected: nothing shifts, tdo holds, no byte.
        bus.ir_is_user = 1'b0;
        scan('0, 8, dout);
        update("ir_low", 1'b0);
        check("ir_low_tdo_held", 64'(dout[7:0]), 64'hFF);
        check("ir_low_tdo_after", 64'(bus.tdo), 64'd1);
        bus.ir_is_user = 1'b1;

        // Reset abandons a scan in progress.
        capture();
        for (int i = 0; i < 5; i++) shift(1'b1, o);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midreset_tdo", 64'(bus.tdo), 64'd0);
        check("midreset_byte_data", 64'(bus.byte_data), 64'd0);
        check("midreset_frame_error", 64'(bus.frame_error), 64'd0);
        update("midreset", 1'b0);
        check("midreset_tdo_post", 64'(bus.tdo), 64'd0);
        check("midreset_byte_data_post", 64'(bus.byte_data), 64'd0);

        // Bad-length scan of 5 bits.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        scan(128'h1F, 5, dout);
        bus.update_dr = 1'b1;
        cyc();
        bus.update_dr = 1'b0;
        check("bad_len_strobe", 64'(bus.byte_valid), 64'd0);
`ifdef JTAG_USER_BRIDGE_FRAME_CHECK_EN
        check("frame_error_set", 64'(bus.frame_error), 64'd1);
`else
        check("frame_error_tied", 64'(bus.frame_error), 64'd0);
`endif
        cyc();
        sb.push_back(8'h5A);
        scan(128'h5A, 8, dout);
        update("byte_5a", 1'b1);
`ifdef JTAG_USER_BRIDGE_FRAME_CHECK_EN
        check("frame_error_sticky", 64'(bus.frame_error), 64'd1);
`else
        check("frame_error_still_0", 64'(bus.frame_error), 64'd0);
`endif
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("frame_error_cleared", 64'(bus.frame_error), 64'd0);

        gap(2);
        check("byte_queue_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/jtag_user_bridge.md
Name: jtag_user_bridge

Overview:
Device-side end of the USER4 JTAG scan-chain protocol. It sits between the BSCANE2 primitive signals and each puzzle's solver core. Inbound DR scans of exactly 8 bits become one input byte, delivered LSB-first as a one-cycle strobe. Outbound DR scans shift the latched solver result out on tdo for host readback.

Parameters:
RESULT_WIDTH, 32, width of the result readback scan; must be > 8 and ≤ 63 (elaboration-time $error otherwise)
BYTE_WIDTH, 8, inbound scan length that qualifies as a data byte

Ports:
tck  input  1  JTAG TCK, the only clock; all logic on posedge
test_logic_reset  input  1  synchronous active-high reset
tdi  input  1  scan data in
tdo  output  1  scan data out; host samples it on the falling edge
run_test_idle  input  1  TAP in Run-Test/Idle (informational, ignored)
ir_is_user  input  1  USER4 instruction selected; all DR activity is ignored while low
capture_dr  input  1  TAP in Capture-DR
shift_dr  input  1  TAP in Shift-DR
update_dr  input  1  TAP in Update-DR
result  input  RESULT_WIDTH  solver result value
result_valid  input  1  one-cycle strobe; latches result
byte_valid  output  1  one-cycle strobe: new inbound byte
byte_data  output  BYTE_WIDTH  inbound byte, bit0 = first shifted bit
frame_error  output  1  sticky bad-length flag (optional feature)

Behaviour:
- Reset (test_logic_reset=1 at posedge): every register clears. Outputs reset to tdo=0, byte_valid=0, byte_data=0, frame_error=0. Result holding register clears to 0. FSM goes to IDLE. Any scan in progress is abandoned, with no byte emitted.
- Qualifier: dr_cap = ir_is_user & capture_dr, dr_shift = ir_is_user & shift_dr, dr_upd = ir_is_user & update_dr.
- FSM states: IDLE, SHIFT, WAIT_UPD.
  - IDLE -> SHIFT on dr_cap.
  - SHIFT stays in SHIFT on dr_shift. On a cycle with no dr_shift it moves to WAIT_UPD (Exit1/Pause/Exit2 states).
  - WAIT_UPD -> SHIFT on dr_shift (Pause resume) or dr_cap.
  - WAIT_UPD -> IDLE on dr_upd.
  - dr_upd seen in any state returns to IDLE.
- Shift counter: 6 bits. Cleared on dr_cap. Incremented on each dr_shift, saturating at 63; it never wraps.
- Inbound shift register: BYTE_WIDTH bits, cleared on dr_cap. On dr_shift: in_sr <= {tdi, in_sr[BYTE_WIDTH-1:1]}, so after 8 shifts the first bit sits at bit0.
- Byte emit: on the posedge where dr_upd is sampled with count == BYTE_WIDTH, byte_data <= in_sr and byte_valid <= 1.
  - Latency is 1 cycle after the update_dr cycle; the strobe lasts exactly 1 cycle.
  - byte_data holds its value until the next emit.
  - No backpressure: a downstream core must accept one byte per strobe.
- Result hold: on result_valid, hold <= result. A later strobe overwrites it.
  - A strobe during a readback scan updates hold only; the in-flight scan is unchanged.
  - result_valid in the same cycle as dr_cap: the capture loads the new result.
- Outbound shift register: RESULT_WIDTH bits.
  - On dr_cap it loads hold, or 0 if no result has been latched yet.
  - On dr_shift: out_sr <= {1'b0, out_sr[RESULT_WIDTH-1:1]}.
  - tdo = out_sr[0] (registered output).
  - Net effect: after the capture posedge, the first falling edge shows bit0, and each later shift posedge exposes the next bit.
  - Shifting past RESULT_WIDTH bits returns 0.
- A host keeps polling until it reads a nonzero result, so a result of 0 is indistinguishable from "not ready". The solver must guarantee a nonzero answer.
- ir_is_user low: the FSM freezes, counters and shift registers hold, and tdo holds its last value.
- Simultaneous capture_dr and shift_dr (illegal TAP state): capture wins.

Optional Feature:
Macro JTAG_USER_BRIDGE_FRAME_CHECK_EN.
- Defined: on dr_upd with count not equal to BYTE_WIDTH and not equal to RESULT_WIDTH, frame_error is set one cycle later. It stays set until reset, and no byte is emitted.
- Undefined: frame_error is tied 0; bad-length scans are silently dropped, with no byte emitted.

Test Plan:
- Reset, capture, 8 shifts of 0x41 LSB-first, exit1, update -> byte_valid=1 for exactly one cycle after update_dr, byte_data=0x41; no other strobes.
- result_valid with 0x0000_1234, then capture + 32 shifts with tdi=0, sampling tdo on each falling edge -> readback 0x00001234; no byte_valid, since count is 32.
- Readback scan before any result_valid -> 0x00000000. Then result_valid 0xDEADBEEF during a scan, followed by a rescan -> the first scan is still 0, the second reads 0xDEADBEEF.
- 4 shifts, pause for 3 cycles, 4 more shifts, update, byte 0x0A -> byte_data=0x0A, byte_valid pulses once.
- ir_is_user=0 while shifting 8 bits and updating -> no byte_valid, tdo unchanged. test_logic_reset asserted after 5 shifts, then update -> no byte_valid, all outputs 0.
- With JTAG_USER_BRIDGE_FRAME_CHECK_EN defined: 5 shifts + update -> frame_error=1 one cycle later; it stays 1 through a following valid byte, clears on reset. Without the macro, frame_error stays 0.
